// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared register map, blink-control fields and PWM counter width
package led_pwm_pkg;
  localparam int PWM_W = 8;
  localparam logic [7:0] BRIGHT_OFS = 8'd0;
  localparam logic [7:0] BLINK_OFS = 8'd1;
  localparam logic [7:0] MASK_LO_OFS = 8'd2;
  localparam logic [7:0] MASK_HI_OFS = 8'd3;
  localparam logic [7:0] NUM_REGS = 8'd4;
  localparam int BLINK_EN_BIT = 7;
  localparam int BLINK_HALF_MSB = 6;
  localparam logic [7:0] BRIGHT_RST = 8'hFF;
endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: prescaler and 8-bit PWM counter with frame strobe
// CLK/RESET: clock, sync active-high reset; pwm_cnt: current PWM level;
// frame: high for the single tick cycle where pwm_cnt wraps 255->0
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 100
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [PWM_W-1:0] pwm_cnt,
  output logic             frame
);
  localparam int PW = $clog2(PRESCALE_DIV);
  logic [PW-1:0] presc_q, presc_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic tick;
  always_comb begin
    tick = presc_q == PW'(PRESCALE_DIV - 1);
    frame = tick & (pwm_q == '1);
    presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_d = tick ? pwm_q + 1'b1 : pwm_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
      pwm_q <= '0;
    end else begin
      presc_q <= presc_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm_cnt = pwm_q;
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: frame-synchronous PWM brightness and per-LED blink for 16 LEDs
// CLK/RESET: clock, sync active-high reset
// BUS_ADDR/BUS_DATA/BUS_WE: write-only register bus (BRIGHT, BLINK_CTRL, MASK_LO, MASK_HI)
// LED_PATTERN: pattern in; LED_OUT: registered pin drive; FRAME_SYNC: pulse after each frame boundary
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC2,
  parameter int PRESCALE_DIV = 100,
  parameter int BLINK_UNIT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  input  logic [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  input  logic [15:0] LED_PATTERN,
  output logic [15:0] LED_OUT,
  output logic        FRAME_SYNC
);
  localparam int CW = $clog2(128 * BLINK_UNIT);
  logic [PWM_W-1:0] pwm_cnt;
  logic frame;
  led_pwm_timebase #(.PRESCALE_DIV(PRESCALE_DIV)) u_timebase (
    .CLK(CLK),
    .RESET(RESET),
    .pwm_cnt(pwm_cnt),
    .frame(frame)
  );
  logic [7:0] ofs;
  logic wr, en, blink_hold, blink_last, pwm_on;
  logic [6:0] half;
  logic [7:0] stg_bright_q, stg_bright_d, stg_blink_q, stg_blink_d;
  logic [15:0] stg_mask_q, stg_mask_d;
  logic [7:0] bright_q, bright_d, blink_q, blink_d;
  logic [15:0] mask_q, mask_d, pattern_q, pattern_d, led_q, led_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic phase_q, phase_d, fs_q, fs_d;
  always_comb begin
    ofs = BUS_ADDR - BASE_ADDR;
    wr = BUS_WE & (ofs < NUM_REGS);
    stg_bright_d = (wr && ofs == BRIGHT_OFS) ? BUS_DATA : stg_bright_q;
    stg_blink_d = (wr && ofs == BLINK_OFS) ? BUS_DATA : stg_blink_q;
    stg_mask_d = {(wr && ofs == MASK_HI_OFS) ? BUS_DATA : stg_mask_q[15:8],
                  (wr && ofs == MASK_LO_OFS) ? BUS_DATA : stg_mask_q[7:0]};
    // active copies take the staging value as it stood before this cycle's write
    bright_d = frame ? stg_bright_q : bright_q;
    blink_d = frame ? stg_blink_q : blink_q;
    mask_d = frame ? stg_mask_q : mask_q;
    pattern_d = frame ? LED_PATTERN : pattern_q;
    en = blink_q[BLINK_EN_BIT];
    half = blink_q[BLINK_HALF_MSB:0];
    blink_hold = !en || half == 7'd0;
    blink_last = int'(blink_cnt_q) == int'(half) * BLINK_UNIT - 1;
    blink_cnt_d = blink_hold ? '0 : frame ? (blink_last ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
    phase_d = blink_hold ? 1'b0 : (frame && blink_last) ? ~phase_q : phase_q;
    pwm_on = bright_q == 8'hFF || pwm_cnt < bright_q;
    led_d = pattern_q & {16{pwm_on}} & ~(mask_q & {16{en & phase_q}});
    fs_d = frame;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stg_bright_q <= BRIGHT_RST;
      stg_blink_q <= '0;
      stg_mask_q <= '0;
      bright_q <= BRIGHT_RST;
      blink_q <= '0;
      mask_q <= '0;
      pattern_q <= '0;
      blink_cnt_q <= '0;
      phase_q <= 1'b0;
      led_q <= '0;
      fs_q <= 1'b0;
    end else begin
      stg_bright_q <= stg_bright_d;
      stg_blink_q <= stg_blink_d;
      stg_mask_q <= stg_mask_d;
      bright_q <= bright_d;
      blink_q <= blink_d;
      mask_q <= mask_d;
      pattern_q <= pattern_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q <= phase_d;
      led_q <= led_d;
      fs_q <= fs_d;
    end
  end
  assign LED_OUT = led_q;
  assign FRAME_SYNC = fs_q;
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: randomized self-checking bench against a frame-level reference model
module tb_led_pwm_driver;
  logic CLK = 1'b0, RESET = 1'b1, BUS_WE = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00, BUS_DATA = 8'h00;
  logic [15:0] LED_PATTERN = 16'h0000;
  logic [15:0] LED_OUT;
  logic FRAME_SYNC;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  led_pwm_driver #(.BASE_ADDR(8'hC2), .PRESCALE_DIV(2), .BLINK_UNIT(1)) dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
    .LED_PATTERN(LED_PATTERN), .LED_OUT(LED_OUT), .FRAME_SYNC(FRAME_SYNC)
  );
  // reference model: position in frame comes from cycles since reset (512-cycle frames)
  int t = 0, m_bcnt = 0;
  logic [7:0] stg [4];
  logic [7:0] act [4];
  logic [15:0] m_pat = 16'h0, m_out = 16'h0;
  logic m_fs = 1'b0, m_phase = 1'b0;
  wire [7:0] w_ofs = BUS_ADDR - 8'hC2;
  wire m_bound = (t % 512) == 511;
  wire [7:0] m_level = 8'((t % 512) / 2);
  wire m_on = act[0] == 8'hFF || m_level < act[0];
  wire m_en = act[1][7];
  wire [6:0] m_half = act[1][6:0];
  wire [15:0] m_mask = {act[3], act[2]};
  always @(posedge CLK) begin
    if (RESET) begin
      t <= 0;
      stg <= '{8'hFF, 8'h00, 8'h00, 8'h00};
      act <= '{8'hFF, 8'h00, 8'h00, 8'h00};
      m_pat <= 16'h0;
      m_out <= 16'h0;
      m_fs <= 1'b0;
      m_phase <= 1'b0;
      m_bcnt <= 0;
    end else begin
      t <= t + 1;
      m_fs <= m_bound;
      m_out <= m_pat & (m_on ? 16'hFFFF : 16'h0000) & ~(m_mask & {16{m_en & m_phase}});
      if (BUS_WE && w_ofs < 8'd4) stg[w_ofs[1:0]] <= BUS_DATA;
      if (m_bound) begin
        act <= stg;
        m_pat <= LED_PATTERN;
      end
      if (!m_en || m_half == 7'd0) begin
        m_bcnt <= 0;
        m_phase <= 1'b0;
      end else if (m_bound) begin
        if (m_bcnt == int'(m_half) - 1) begin
          m_bcnt <= 0;
          m_phase <= ~m_phase;
        end else m_bcnt <= m_bcnt + 1;
      end
    end
  end
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    BUS_ADDR = a;
    BUS_DATA = d;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask
  task automatic sync_frame;
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!FRAME_SYNC && n < 600);
    checks++;
    if (FRAME_SYNC !== 1'b1) begin
      errors++;
      $display("FAIL frame_sync_timeout got=%b exp=1 within 600 cycles", FRAME_SYNC);
    end
  endtask
  task automatic test_reset;
    int bad = 0;
    RESET = 1'b1;
    LED_PATTERN = 16'hFFFF;
    repeat (3) @(negedge CLK);
    checks++;
    if (LED_OUT !== 16'h0) begin errors++; $display("FAIL reset_led got=%h exp=0000", LED_OUT); end
    checks++;
    if (FRAME_SYNC !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", FRAME_SYNC); end
    RESET = 1'b0;
    for (int i = 0; i < 512; i++) begin
      @(negedge CLK);
      if (LED_OUT !== 16'h0 || (i < 511 && FRAME_SYNC !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL first_frame_dark bad_cycles=%0d exp=0", bad); end
    checks++;
    if (FRAME_SYNC !== 1'b1) begin errors++; $display("FAIL first_fs_at_512 got=%b exp=1", FRAME_SYNC); end
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (LED_OUT !== 16'hFFFF || LED_OUT !== m_out || FRAME_SYNC !== m_fs) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_on bad_cycles=%0d exp=0", bad); end
  endtask
  task automatic test_bright;
    int hi = 0, bad = 0;
    sync_frame();
    LED_PATTERN = 16'($urandom) | 16'h0020;
    bus_write(8'hC2, 8'h40);
    sync_frame();
    for (int i = 0; i < 512; i++) begin
      @(negedge CLK);
      if (LED_OUT[5]) hi++;
      if (LED_OUT !== m_out || FRAME_SYNC !== m_fs) bad++;
    end
    checks++;
    if (hi != 128) begin errors++; $display("FAIL bright40_duty got=%0d exp=128", hi); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bright40_model bad_cycles=%0d exp=0", bad); end
    bus_write(8'hC2, 8'h00);
    sync_frame();
    hi = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge CLK);
      if (LED_OUT !== 16'h0) hi++;
    end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL bright0_off lit_cycles=%0d exp=0", hi); end
  endtask
  task automatic test_blink;
    logic s [8];
    int bad = 0, b1 = 0, alt = 0;
    sync_frame();
    LED_PATTERN = 16'h0003;
    bus_write(8'hC2, 8'hFF);
    bus_write(8'hC3, 8'h82);
    bus_write(8'hC4, 8'h01);
    bus_write(8'hC5, 8'h00);
    sync_frame();
    for (int f = 0; f < 8; f++)
      for (int i = 0; i < 512; i++) begin
        @(negedge CLK);
        if (i == 256) s[f] = LED_OUT[0];
        if (LED_OUT[1] !== 1'b1 || LED_OUT[15:2] !== 14'h0) b1++;
        if (LED_OUT !== m_out || FRAME_SYNC !== m_fs) bad++;
      end
    for (int f = 0; f < 6; f++) if (s[f] === s[f+2]) alt++;
    checks++;
    if (alt != 0 || s[0] !== 1'b1) begin
      errors++;
      $display("FAIL blink_2on_2off frames=%b%b%b%b%b%b%b%b exp=11001100", s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]);
    end
    checks++;
    if (b1 != 0) begin errors++; $display("FAIL blink_unmasked bad_cycles=%0d exp=0", b1); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL blink_model bad_cycles=%0d exp=0", bad); end
  endtask
  task automatic test_boundary_write;
    int hi0 = 0, hi1 = 0;
    sync_frame();
    LED_PATTERN = 16'hFFFF;
    bus_write(8'hC3, 8'h00);
    bus_write(8'hC2, 8'hFF);
    sync_frame();
    for (int i = 0; i < 600 && (t % 512) != 511; i++) @(negedge CLK);
    BUS_ADDR = 8'hC2;
    BUS_DATA = 8'h10;
    BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    checks++;
    if (FRAME_SYNC !== 1'b1) begin errors++; $display("FAIL boundary_align fs=%b exp=1", FRAME_SYNC); end
    for (int i = 0; i < 512; i++) begin @(negedge CLK); if (LED_OUT[0]) hi0++; end
    for (int i = 0; i < 512; i++) begin @(negedge CLK); if (LED_OUT[0]) hi1++; end
    checks++;
    if (hi0 != 512) begin errors++; $display("FAIL boundary_old_value got=%0d exp=512", hi0); end
    checks++;
    if (hi1 != 32) begin errors++; $display("FAIL boundary_new_value got=%0d exp=32", hi1); end
  endtask
  task automatic test_reset_mid;
    int n = 0, bad = 0;
    LED_PATTERN = 16'hFFFF;
    bus_write(8'hC2, 8'h80);
    bus_write(8'hC3, 8'h81);
    bus_write(8'hC4, 8'hFF);
    bus_write(8'hC5, 8'hFF);
    sync_frame();
    sync_frame();
    repeat (200 + $urandom_range(0, 100)) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checks++;
    if (LED_OUT !== 16'h0) begin errors++; $display("FAIL midreset_led got=%h exp=0000", LED_OUT); end
    checks++;
    if (FRAME_SYNC !== 1'b0) begin errors++; $display("FAIL midreset_fs got=%b exp=0", FRAME_SYNC); end
    do begin
      @(negedge CLK);
      n++;
      if (LED_OUT !== m_out) bad++;
    end while (FRAME_SYNC !== 1'b1 && n < 1000);
    checks++;
    if (n != 512) begin errors++; $display("FAIL midreset_first_fs got=%0d exp=512", n); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_model bad_cycles=%0d exp=0", bad); end
  endtask
  task automatic test_bad_addr;
    int bad = 0;
    logic [15:0] p;
    p = 16'($urandom) | 16'h8001;
    LED_PATTERN = p;
    sync_frame();
    bus_write(8'hC1, 8'h00);
    bus_write(8'hC6, 8'h00);
    bus_write(8'hC1, 8'($urandom));
    bus_write(8'hC6, 8'($urandom));
    sync_frame();
    for (int i = 0; i < 1024; i++) begin
      @(negedge CLK);
      if (LED_OUT !== p || LED_OUT !== m_out) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bad_addr_ignored bad_cycles=%0d exp=0", bad); end
  endtask
  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 512 * 8; i++) begin
      @(negedge CLK);
      if (LED_OUT !== m_out || FRAME_SYNC !== m_fs) bad++;
      BUS_WE = $urandom_range(0, 40) == 0;
      BUS_ADDR = 8'hC0 + 8'($urandom_range(0, 7));
      BUS_DATA = 8'($urandom);
      if (BUS_ADDR == 8'hC3) BUS_DATA = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 3))};
      if ($urandom_range(0, 200) == 0) LED_PATTERN = 16'($urandom);
    end
    BUS_WE = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_model bad_cycles=%0d exp=0", bad); end
  endtask
  initial begin
    test_reset();
    test_bright();
    test_blink();
    test_boundary_write();
    test_reset_mid();
    test_bad_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
